fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined CPU: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by the decode stage. It sits directly upstream of decode, which returns stall and redirect (branch/jump/return) requests. Two 32-bit performance counters (fetched instructions, stall cycles) are included for the pipeline testbench.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, decode feedback, IF/ID payload and counters.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  // Environment side: memory and decode stage.
  modport master (
    input  imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid,
           fetch_count, stall_count,
    output imem_data, stall, redirect_valid, redirect_target
  );

  // Fetch-stage side.
  modport slave (
    output imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid,
           fetch_count, stall_count,
    input  imem_data, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and fetch/stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);
  localparam int unsigned W = 32;

  logic [W-1:0] pc_q,          pc_d;
  logic [W-1:0] ifid_instr_q,  ifid_instr_d;
  logic [W-1:0] ifid_pc_q,     ifid_pc_d;
  logic [W-1:0] ifid_pc_p1_q,  ifid_pc_p1_d;
  logic         ifid_valid_q,  ifid_valid_d;
  logic [W-1:0] fetch_cnt_q,   fetch_cnt_d;
  logic [W-1:0] stall_cnt_q,   stall_cnt_d;
  logic [W-1:0] pc_plus1;

  assign pc_plus1 = pc_q + W'(1);

  // Next-state: redirect beats stall beats normal fetch.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc_p1_d = ifid_pc_p1_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bus.redirect_valid) begin
      // Wrong-path word is dropped; bubble keeps the previous PC fields.
      pc_d         = bus.redirect_target;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (bus.stall) begin
      stall_cnt_d  = stall_cnt_q + W'(1);
    end else begin
      pc_d         = pc_plus1;
      ifid_instr_d = bus.imem_data;
      ifid_pc_d    = pc_q;
      ifid_pc_p1_d = pc_plus1;
      ifid_valid_d = 1'b1;
      fetch_cnt_d  = fetch_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc_p1_q <= '0;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc_p1_q <= ifid_pc_p1_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc       = ifid_pc_q;
  assign bus.ifid_pc_plus1 = ifid_pc_p1_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.fetch_count   = fetch_cnt_q;
  assign bus.stall_count   = stall_cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: startup, stall, redirect, priority, PC wrap, async reset.
module tb_fetch_stage;
  logic clk;
  logic rst;
  logic rst_w;
  int   vectors;
  int   errors;

  fetch_stage_if f_if ();
  fetch_stage_if w_if ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(f_if)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFE), .NOP_INSTR(32'h0000_0000)) dut_wrap (
    .clk(clk), .rst(rst_w), .bus(w_if)
  );

  // Memory model: word i holds 0x1000_0000 + i.
  assign f_if.imem_data = 32'h1000_0000 + f_if.imem_addr;
  assign w_if.imem_data = 32'h1000_0000 + w_if.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    f_if.stall = 1'b0; f_if.redirect_valid = 1'b0; f_if.redirect_target = '0;
    #1;
    vectors++;
    if (f_if.imem_addr !== 32'h0 || f_if.ifid_valid !== 1'b0 ||
        f_if.fetch_count !== 32'h0 || f_if.stall_count !== 32'h0 ||
        f_if.ifid_instr !== 32'h0) begin
      $display("FAIL reset_state addr=%h valid=%b fc=%h sc=%h instr=%h required 0/0/0/0/0",
               f_if.imem_addr, f_if.ifid_valid, f_if.fetch_count, f_if.stall_count, f_if.ifid_instr);
      errors++;
    end
    step(); step();
    vectors++;
    if (f_if.imem_addr !== 32'h0 || f_if.ifid_valid !== 1'b0) begin
      $display("FAIL reset_hold addr=%h valid=%b required 0/0", f_if.imem_addr, f_if.ifid_valid);
      errors++;
    end
    rst = 1'b1;
  endtask

  task automatic test_startup();
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (f_if.ifid_instr !== 32'h1000_0000 + 32'(i) || f_if.ifid_pc !== 32'(i) ||
          f_if.ifid_pc_plus1 !== 32'(i + 1) || f_if.ifid_valid !== 1'b1 ||
          f_if.imem_addr !== 32'(i + 1)) begin
        $display("FAIL startup_%0d instr=%h pc=%h pc1=%h valid=%b addr=%h required %h/%h/%h/1/%h",
                 i, f_if.ifid_instr, f_if.ifid_pc, f_if.ifid_pc_plus1, f_if.ifid_valid,
                 f_if.imem_addr, 32'h1000_0000 + 32'(i), 32'(i), 32'(i + 1), 32'(i + 1));
        errors++;
      end
    end
    vectors++;
    if (f_if.fetch_count !== 32'd3) begin
      $display("FAIL startup_fetch_count got=%0d required 3", f_if.fetch_count);
      errors++;
    end
  endtask

  task automatic test_stall();
    step(); step();
    f_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (f_if.ifid_pc !== 32'd4 || f_if.imem_addr !== 32'd5 ||
          f_if.fetch_count !== 32'd5 || f_if.stall_count !== 32'(i + 1) ||
          f_if.ifid_instr !== 32'h1000_0004) begin
        $display("FAIL stall_%0d pc=%h addr=%h fc=%0d sc=%0d instr=%h required 4/5/5/%0d/10000004",
                 i, f_if.ifid_pc, f_if.imem_addr, f_if.fetch_count, f_if.stall_count,
                 f_if.ifid_instr, i + 1);
        errors++;
      end
    end
    f_if.stall = 1'b0;
    step();
    vectors++;
    if (f_if.ifid_pc !== 32'd5 || f_if.ifid_instr !== 32'h1000_0005 ||
        f_if.fetch_count !== 32'd6 || f_if.stall_count !== 32'd3 || f_if.imem_addr !== 32'd6) begin
      $display("FAIL stall_resume pc=%h instr=%h fc=%0d sc=%0d addr=%h required 5/10000005/6/3/6",
               f_if.ifid_pc, f_if.ifid_instr, f_if.fetch_count, f_if.stall_count, f_if.imem_addr);
      errors++;
    end
  endtask

  task automatic test_redirect();
    step();
    f_if.redirect_valid = 1'b1; f_if.redirect_target = 32'h40;
    step();
    vectors++;
    if (f_if.imem_addr !== 32'h40 || f_if.ifid_valid !== 1'b0 || f_if.ifid_instr !== 32'h0 ||
        f_if.ifid_pc !== 32'd6 || f_if.fetch_count !== 32'd7) begin
      $display("FAIL redirect_bubble addr=%h valid=%b instr=%h pc=%h fc=%0d required 40/0/0/6/7",
               f_if.imem_addr, f_if.ifid_valid, f_if.ifid_instr, f_if.ifid_pc, f_if.fetch_count);
      errors++;
    end
    f_if.redirect_valid = 1'b0; f_if.redirect_target = '0;
    step();
    vectors++;
    if (f_if.ifid_pc !== 32'h40 || f_if.ifid_instr !== 32'h1000_0040 ||
        f_if.ifid_valid !== 1'b1 || f_if.ifid_pc_plus1 !== 32'h41 || f_if.fetch_count !== 32'd8) begin
      $display("FAIL redirect_target pc=%h instr=%h valid=%b pc1=%h fc=%0d required 40/10000040/1/41/8",
               f_if.ifid_pc, f_if.ifid_instr, f_if.ifid_valid, f_if.ifid_pc_plus1, f_if.fetch_count);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    f_if.stall = 1'b1; f_if.redirect_valid = 1'b1; f_if.redirect_target = 32'h20;
    step();
    vectors++;
    if (f_if.imem_addr !== 32'h20 || f_if.ifid_valid !== 1'b0 || f_if.stall_count !== 32'd3) begin
      $display("FAIL simul_priority addr=%h valid=%b sc=%0d required 20/0/3",
               f_if.imem_addr, f_if.ifid_valid, f_if.stall_count);
      errors++;
    end
    f_if.stall = 1'b0; f_if.redirect_target = 32'h30;
    step();
    vectors++;
    if (f_if.imem_addr !== 32'h30 || f_if.ifid_valid !== 1'b0 || f_if.fetch_count !== 32'd8) begin
      $display("FAIL b2b_second addr=%h valid=%b fc=%0d required 30/0/8",
               f_if.imem_addr, f_if.ifid_valid, f_if.fetch_count);
      errors++;
    end
    f_if.redirect_valid = 1'b0;
    step();
    vectors++;
    if (f_if.ifid_pc !== 32'h30 || f_if.ifid_instr !== 32'h1000_0030 ||
        f_if.ifid_valid !== 1'b1 || f_if.fetch_count !== 32'd9) begin
      $display("FAIL b2b_resume pc=%h instr=%h valid=%b fc=%0d required 30/10000030/1/9",
               f_if.ifid_pc, f_if.ifid_instr, f_if.ifid_valid, f_if.fetch_count);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    f_if.redirect_valid = 1'b1; f_if.redirect_target = 32'd9;
    step();
    f_if.redirect_valid = 1'b0; f_if.stall = 1'b1;
    step();
    vectors++;
    if (f_if.imem_addr !== 32'd9 || f_if.stall_count !== 32'd4) begin
      $display("FAIL pre_reset_stall addr=%h sc=%0d required 9/4", f_if.imem_addr, f_if.stall_count);
      errors++;
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (f_if.imem_addr !== 32'h0 || f_if.ifid_valid !== 1'b0 || f_if.ifid_pc !== 32'h0 ||
        f_if.ifid_pc_plus1 !== 32'h0 || f_if.fetch_count !== 32'h0 || f_if.stall_count !== 32'h0) begin
      $display("FAIL async_reset addr=%h valid=%b pc=%h pc1=%h fc=%0d sc=%0d required all 0",
               f_if.imem_addr, f_if.ifid_valid, f_if.ifid_pc, f_if.ifid_pc_plus1,
               f_if.fetch_count, f_if.stall_count);
      errors++;
    end
    f_if.stall = 1'b0;
    #1 rst = 1'b1;
    step();
    vectors++;
    if (f_if.ifid_pc !== 32'h0 || f_if.ifid_instr !== 32'h1000_0000 ||
        f_if.ifid_valid !== 1'b1 || f_if.fetch_count !== 32'd1 || f_if.imem_addr !== 32'd1) begin
      $display("FAIL reset_restart pc=%h instr=%h valid=%b fc=%0d addr=%h required 0/10000000/1/1/1",
               f_if.ifid_pc, f_if.ifid_instr, f_if.ifid_valid, f_if.fetch_count, f_if.imem_addr);
      errors++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_p1 [3];
    logic [31:0] exp_in [3];
    exp_pc[0] = 32'hFFFF_FFFE; exp_p1[0] = 32'hFFFF_FFFF; exp_in[0] = 32'h0FFF_FFFE;
    exp_pc[1] = 32'hFFFF_FFFF; exp_p1[1] = 32'h0000_0000; exp_in[1] = 32'h0FFF_FFFF;
    exp_pc[2] = 32'h0000_0000; exp_p1[2] = 32'h0000_0001; exp_in[2] = 32'h1000_0000;
    vectors++;
    if (w_if.imem_addr !== 32'hFFFF_FFFE) begin
      $display("FAIL wrap_reset_pc addr=%h required fffffffe", w_if.imem_addr);
      errors++;
    end
    rst_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (w_if.ifid_pc !== exp_pc[i] || w_if.ifid_pc_plus1 !== exp_p1[i] ||
          w_if.ifid_instr !== exp_in[i] || w_if.ifid_valid !== 1'b1) begin
        $display("FAIL wrap_%0d pc=%h pc1=%h instr=%h valid=%b required %h/%h/%h/1",
                 i, w_if.ifid_pc, w_if.ifid_pc_plus1, w_if.ifid_instr, w_if.ifid_valid,
                 exp_pc[i], exp_p1[i], exp_in[i]);
        errors++;
      end
    end
    vectors++;
    if (w_if.imem_addr !== 32'd1) begin
      $display("FAIL wrap_next_addr addr=%h required 1", w_if.imem_addr);
      errors++;
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_w   = 1'b0;
    w_if.stall = 1'b0; w_if.redirect_valid = 1'b0; w_if.redirect_target = '0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
